// File: rtl/fpu_issue.sv
// FP op issue unit: queues core ops, issues one at a time to a multi-cycle FPU
// with a request timeout, and holds each result for the writeback handshake.
module fpu_issue #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [6:0]  in_funct7,
    input  logic [2:0]  in_funct3,
    input  logic        in_rs2b0,
    input  logic [4:0]  in_rd,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [6:0]  fpu_funct7,
    output logic [2:0]  fpu_funct3,
    output logic        fpu_rs2b0,
    output logic        fpu_valid,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_r,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned EW   = 80;
    localparam int unsigned LAST = TIMEOUT - 1;
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];
    localparam logic [CW-1:0]  LAST_CNT = LAST[CW-1:0];

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e           state_q, state_d;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [CW-1:0]    cnt_q;
    logic [4:0]       req_rd_q;
    logic             full, empty, push, pop, expire;
    logic [EW-1:0]    head;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    // Full is judged before any same-cycle pop, so a full queue never accepts.
    assign push     = in_valid && !full;
    assign pop      = (state_q == StIdle) && !empty;
    assign expire   = (cnt_q == LAST_CNT);
    assign head     = mem[rd_ptr_q];

    // Queue storage; entries are only read after their pointer update, so no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_rd, in_rs2b0, in_funct3, in_funct7, in_b, in_a};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state; completion wins over an expiring timeout on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StReq;
            StReq: begin
                if (fpu_ready)   state_d = StDone;
                else if (expire) state_d = StIdle;
            end
            StDone:  if (wb_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; request drops outside REQ so the FPU always sees a low gap.
    always_comb begin
        fpu_valid = (state_q == StReq);
        wb_valid  = (state_q == StDone);
        busy      = !empty || (state_q != StIdle);
    end

    // Issue/writeback registers, REQ cycle counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_funct7  <= '0;
            fpu_funct3  <= '0;
            fpu_rs2b0   <= 1'b0;
            req_rd_q    <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                {req_rd_q, fpu_rs2b0, fpu_funct3, fpu_funct7, fpu_b, fpu_a} <= head;
                cnt_q <= '0;
            end
            if (state_q == StReq) begin
                cnt_q <= cnt_q + CW'(1);
                if (fpu_ready) begin
                    wb_data <= fpu_r;
                    wb_rd   <= req_rd_q;
                end else if (expire) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: FPU model with delay D=1, writeback scoreboard.
module tb_fpu_issue;

    localparam int FPU_D = 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clock, reset;
    logic        in_valid, in_ready, in_rs2b0;
    logic [31:0] in_a, in_b;
    logic [6:0]  in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] fpu_a, fpu_b, fpu_r, wb_data;
    logic [6:0]  fpu_funct7;
    logic [2:0]  fpu_funct3;
    logic        fpu_rs2b0, fpu_valid, fpu_ready;
    logic        wb_valid, wb_ready, busy, timeout_err;
    logic [4:0]  wb_rd;

    logic        fpu_en, spur;
    int          vcnt;
    exp_t        sb[$];
    int          n_cmp = 0, n_err = 0;
    int          wb_n = 0, req_starts = 0;
    logic        prev_fv = 1'b0;
    logic [74:0] prev_op = '0;

    fpu_issue #(.DEPTH(2), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs2b0(in_rs2b0), .in_rd(in_rd),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_funct7(fpu_funct7), .fpu_funct3(fpu_funct3),
        .fpu_rs2b0(fpu_rs2b0), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_r(fpu_r),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [6:0] f7, input logic [2:0] f3,
                                           input logic r0);
        return a + b + {21'b0, f7, f3, r0};
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FPU model: result pulse in the (D+1)th cycle of a held request.
    always @(posedge clock) begin
        if (!fpu_en || !fpu_valid) vcnt <= 0;
        else                       vcnt <= vcnt + 1;
    end
    assign fpu_ready = (fpu_en && fpu_valid && vcnt == FPU_D) || spur;
    assign fpu_r     = fmodel(fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0);

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Writeback scoreboard and request-stability monitor.
    always @(negedge clock) begin
        #1;
        if (reset) begin
            prev_fv = 1'b0;
        end else begin
            if (wb_valid && wb_ready) begin
                wb_n++;
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (fpu_valid && prev_fv)
                chk("fpu_op_stable", {fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0}, prev_op);
            if (fpu_valid && !prev_fv) req_starts++;
            prev_fv = fpu_valid;
            prev_op = {fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0};
        end
    end

    task automatic push_op(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input bit expect_wb);
        bit acc;
        exp_t e;
        in_valid  = 1'b1;
        in_rd     = rd;
        in_a      = a;
        in_b      = b;
        in_funct7 = 7'h00;
        in_funct3 = 3'b111;
        in_rs2b0  = rd[0];
        if (expect_wb) begin
            e.rd   = rd;
            e.data = fmodel(a, b, 7'h00, 3'b111, rd[0]);
            sb.push_back(e);
        end
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = in_ready;
            @(negedge clock);
        end
        if (!acc) chk("push_accept", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clock);
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_wb(input int budget);
        for (int i = 0; i < budget && !wb_valid; i++) @(negedge clock);
        chk("wait_wb", wb_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts0, wb0;
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b1; fpu_en = 1'b1; spur = 1'b0;
        in_a = '0; in_b = '0; in_funct7 = '0; in_funct3 = '0; in_rs2b0 = 1'b0; in_rd = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fpu_valid", fpu_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_fpu_ops", {fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0}, 0);
        chk("rst_wb", {wb_rd, wb_data}, 0);

        // Single-op latency: enqueue at E0, wb_valid after E3
        push_op(5'd5, 32'h3F800000, 32'h40000000, 1'b1);
        chk("lat_e0_fpu_valid", fpu_valid, 0);
        chk("lat_e0_busy", busy, 1);
        @(negedge clock);
        chk("lat_e1_fpu_valid", fpu_valid, 1);
        chk("lat_e1_fpu_a", fpu_a, 32'h3F800000);
        chk("lat_e1_fpu_b", fpu_b, 32'h40000000);
        @(negedge clock);
        chk("lat_e2_wb_valid", wb_valid, 0);
        @(negedge clock);
        chk("lat_e3_wb_valid", wb_valid, 1);
        chk("lat_e3_wb_rd", wb_rd, 5);
        chk("lat_e3_fpu_valid", fpu_valid, 0);
        @(negedge clock);
        chk("lat_e4_wb_valid", wb_valid, 0);
        chk("lat_e4_busy", busy, 0);

        // Back-to-back ops into a 2-deep queue, in-order writeback
        starts0 = req_starts; wb0 = wb_n;
        push_op(5'd1, 32'h00000011, 32'h00000100, 1'b1);
        push_op(5'd2, 32'h00000022, 32'h00000200, 1'b1);
        push_op(5'd3, 32'h00000033, 32'h00000300, 1'b1);
        chk("full_in_ready", in_ready, 0);
        push_op(5'd4, 32'h00000044, 32'h00000400, 1'b1);
        wait_idle(60);
        chk("b2b_req_starts", req_starts - starts0, 4);
        chk("b2b_wb_count", wb_n - wb0, 4);

        // Writeback stall: DONE holds while wb_ready is low
        wb_ready = 1'b0;
        starts0 = req_starts;
        push_op(5'd7, 32'hDEAD0000, 32'h0000BEEF, 1'b1);
        push_op(5'd8, 32'h12345678, 32'h11111111, 1'b1);
        wait_wb(20);
        e = sb[0];
        for (int i = 0; i < 10; i++) begin
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_rd", wb_rd, e.rd);
            chk("stall_wb_data", wb_data, e.data);
            chk("stall_fpu_valid", fpu_valid, 0);
            @(negedge clock);
        end
        chk("stall_no_issue", req_starts - starts0, 1);
        wb_ready = 1'b1;
        wait_idle(40);

        // Spurious fpu_ready in IDLE is ignored
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        @(negedge clock);
        chk("spur_wb_valid", wb_valid, 0);
        chk("spur_fpu_valid", fpu_valid, 0);
        chk("spur_busy", busy, 0);

        // Timeout: FPU silent for 8 REQ cycles, then the next op issues normally
        fpu_en = 1'b0;
        push_op(5'd9, 32'h0000AAAA, 32'h00005555, 1'b0);
        push_op(5'd10, 32'h00000100, 32'h00000001, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("to_req_fpu_valid", fpu_valid, 1);
            chk("to_req_err", timeout_err, 0);
            @(negedge clock);
        end
        chk("to_abort_fpu_valid", fpu_valid, 0);
        chk("to_abort_err", timeout_err, 1);
        chk("to_abort_wb_valid", wb_valid, 0);
        chk("to_abort_busy", busy, 1);
        fpu_en = 1'b1;
        wait_idle(40);
        chk("to_sticky_err", timeout_err, 1);

        // Reset during REQ with two ops queued
        fpu_en = 1'b0;
        push_op(5'd11, 32'h1, 32'h2, 1'b0);
        push_op(5'd12, 32'h3, 32'h4, 1'b0);
        push_op(5'd13, 32'h5, 32'h6, 1'b0);
        chk("mr_pre_fpu_valid", fpu_valid, 1);
        chk("mr_pre_in_ready", in_ready, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        chk("mr_fpu_valid", fpu_valid, 0);
        chk("mr_wb_valid", wb_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_timeout_err", timeout_err, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        fpu_en = 1'b1;
        repeat (3) @(negedge clock);
        chk("mr_post_busy", busy, 0);
        push_op(5'd14, 32'h00ABCDEF, 32'h01000000, 1'b1);
        wait_idle(40);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter DEPTH, default 2: input op queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 1024: max cycles in REQ before abort.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  core offers an FP op.
REQ-006 in_ready  output  1  queue can accept; equals !full.
REQ-007 in_a, in_b  input  32 each  operands.
REQ-008 in_funct7 input 7, in_funct3 input 3, in_rs2b0 input 1  opcode fields.
REQ-009 in_rd  input  5  destination register tag.
REQ-010 fpu_a, fpu_b output 32; fpu_funct7 output 7; fpu_funct3 output 3; fpu_rs2b0 output 1  registered op to FPU.
REQ-011 fpu_valid  output  1  request to FPU.
REQ-012 fpu_ready  input  1  one-cycle FPU completion pulse.
REQ-013 fpu_r  input  32  FPU result, valid when fpu_ready=1.
REQ-014 wb_valid output 1, wb_ready input 1  writeback handshake.
REQ-015 wb_rd output 5, wb_data output 32  writeback tag/result.
REQ-016 busy  output  1  queue non-empty or state != IDLE.
REQ-017 timeout_err  output  1  sticky abort flag.

Function
REQ-018 Enqueue on edge with in_valid && in_ready; FIFO order; no enqueue when full, even if a pop occurs same cycle.
REQ-019 States IDLE, REQ, DONE; encoding free.
REQ-020 IDLE: queue non-empty at edge -> pop head into fpu_* registers, go REQ.
REQ-021 REQ: fpu_valid=1; fpu_* operands/opcode held stable for whole state.
REQ-022 REQ, fpu_ready sampled 1 -> capture fpu_r into wb_data, head rd into wb_rd, go DONE.
REQ-023 fpu_valid SHALL be 0 in IDLE and DONE, guaranteeing >=1 low cycle between consecutive FPU requests (FPU restarts compute if valid stays high).
REQ-024 DONE: wb_valid=1, wb_rd/wb_data stable until wb_ready; on wb_valid && wb_ready go IDLE.
REQ-025 fpu_ready while not in REQ SHALL be ignored.
REQ-026 REQ cycle counter counts from 0 on entry; fpu_ready and counter==TIMEOUT-1 same edge -> fpu_ready wins (normal completion).
REQ-027 counter==TIMEOUT-1 without fpu_ready -> discard op, set timeout_err=1, go IDLE; no writeback for that op.
REQ-028 timeout_err remains 1 until reset; issue continues after abort.
REQ-029 Latency: op enqueued into empty idle unit at edge E0, FPU delay D -> wb_valid first high after edge E0+D+2.
REQ-030 Throughput: one op per D+3 cycles minimum when wb_ready held 1.
REQ-031 Queue pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-032 reset=1 at edge: state IDLE, queue empty, counter 0, timeout_err=0.
REQ-033 Outputs after reset: in_ready=1, fpu_valid=0, wb_valid=0, busy=0, fpu_*=0, wb_rd=0, wb_data=0.
REQ-034 Reset mid-REQ or mid-DONE: op and pending writeback discarded; in_valid ignored while reset=1.

Verification
REQ-035 FPU model D=1, enqueue a=0x3F800000 b=0x40000000 rd=5 at E0, wb_ready=1 -> wb_valid high after E3, wb_rd=5, wb_data=model result, fpu_valid low after E3.
REQ-036 Enqueue 3 ops back-to-back, DEPTH=2 -> in_ready=0 once 2 held; writebacks in order rd 1,2,3; fpu_valid low >=1 cycle between requests.
REQ-037 wb_ready=0 for 10 cycles in DONE -> wb_valid, wb_rd, wb_data constant; fpu_valid stays 0; next op not issued until handshake.
REQ-038 TIMEOUT=8, FPU never ready -> after 8 REQ cycles fpu_valid=0, timeout_err=1, no wb_valid; next queued op issues normally.
REQ-039 Assert reset during REQ with 2 ops queued -> next cycle fpu_valid=0, wb_valid=0, busy=0, in_ready=1.
REQ-040 Spurious fpu_ready pulse in IDLE -> no state change, no wb_valid.
